// File: rtl/cmac_slcg_pkg.sv
// ============================================================================
// Module  : cmac_slcg_pkg
// Brief   : Shared state encoding and defaults for the CMAC core SLCG enable.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cmac_slcg_pkg;

    typedef logic [1:0] slcg_state_t;

    localparam slcg_state_t c_st_active = 2'd0;
    localparam slcg_state_t c_st_drain  = 2'd1;
    localparam slcg_state_t c_st_gated  = 2'd2;

    localparam int c_hold_cycles_def = 16;

    // True when any datapath valid is asserted (excludes the layer enable level).
    function automatic logic dp_valid(input logic dat, input logic wt, input logic mac);
        return dat | wt | mac;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmac_slcg_en_ctrl_if.sv
// ============================================================================
// Module  : cmac_slcg_en_ctrl_if
// Brief   : Control, activity and status bundle of the CMAC SLCG enable block.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface cmac_slcg_en_ctrl_if #(
    parameter int PERF_W = 32
);
    logic              reg2dp_op_en;
    logic              reg2dp_slcg_op_en;
    logic              sc2mac_dat_pvld;
    logic              sc2mac_wt_pvld;
    logic              mac2accu_pvld;
    logic              perf_clr;
    logic              slcg_en_src_0;
    logic              slcg_en_src_1;
    logic [PERF_W-1:0] dp2reg_slcg_gated_cnt;
    logic              dp2reg_slcg_viol;

    modport master (
        output reg2dp_op_en, reg2dp_slcg_op_en, sc2mac_dat_pvld,
               sc2mac_wt_pvld, mac2accu_pvld, perf_clr,
        input  slcg_en_src_0, slcg_en_src_1, dp2reg_slcg_gated_cnt,
               dp2reg_slcg_viol
    );

    modport slave (
        input  reg2dp_op_en, reg2dp_slcg_op_en, sc2mac_dat_pvld,
               sc2mac_wt_pvld, mac2accu_pvld, perf_clr,
        output slcg_en_src_0, slcg_en_src_1, dp2reg_slcg_gated_cnt,
               dp2reg_slcg_viol
    );
endinterface

`default_nettype wire

// File: rtl/cmac_slcg_perf_cnt.sv
// ============================================================================
// Module  : cmac_slcg_perf_cnt
// Brief   : Saturating up-counter with synchronous clear (clear wins).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cmac_slcg_perf_cnt #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_inc,
    output logic      [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !(&r_cnt)) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/cmac_slcg_en_ctrl.sv
// ============================================================================
// Module  : cmac_slcg_en_ctrl
// Brief   : CMAC core SLCG enable generation with drain hold and perf status.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cmac_slcg_en_ctrl
    import cmac_slcg_pkg::*;
#(
    parameter int HOLD_CYCLES = c_hold_cycles_def,
    parameter int CNT_W       = 5,
    parameter int PERF_W      = 32
) (
    input  wire logic      nvdla_core_clk,
    input  wire logic      nvdla_core_rst,
    cmac_slcg_en_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] c_cnt_reload = CNT_W'(HOLD_CYCLES - 1);

    slcg_state_t      r_state;
    slcg_state_t      w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_act;
    logic             w_dp_vld;
    logic             w_en0_next;
    logic             r_en0;
    logic             r_en1;
    logic             r_viol;
    logic             w_perf_inc;

    assign w_dp_vld = dp_valid(bus.sc2mac_dat_pvld, bus.sc2mac_wt_pvld, bus.mac2accu_pvld);
    assign w_act    = bus.reg2dp_op_en | w_dp_vld;

    // State register: reset lands in a full drain so the clock runs briefly after reset.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_state <= c_st_drain;
            r_cnt   <= c_cnt_reload;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        if (w_act) begin
            w_next_state = c_st_active;
            w_next_cnt   = c_cnt_reload;
        end else begin
            case (r_state)
                c_st_active: begin
                    w_next_state = c_st_drain;
                    w_next_cnt   = c_cnt_reload;
                end
                c_st_drain: begin
                    if (r_cnt != '0) begin
                        w_next_cnt = r_cnt - CNT_W'(1);
                    end else begin
                        w_next_state = c_st_gated;
                    end
                end
                c_st_gated: begin
                    w_next_state = c_st_gated;
                end
                default: begin
                    w_next_state = c_st_drain;
                    w_next_cnt   = c_cnt_reload;
                end
            endcase
        end
    end

    always_comb begin
        w_en0_next = (w_next_state != c_st_gated);
    end

    // A set on the same edge as perf_clr must survive, so set is tested first.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_en0  <= 1'b1;
            r_en1  <= 1'b1;
            r_viol <= 1'b0;
        end else begin
            r_en0 <= w_en0_next;
            r_en1 <= ~bus.reg2dp_slcg_op_en;
            if (w_dp_vld && !r_en0) begin
                r_viol <= 1'b1;
            end else if (bus.perf_clr) begin
                r_viol <= 1'b0;
            end
        end
    end

    assign w_perf_inc = ~r_en0 & ~r_en1;

    cmac_slcg_perf_cnt #(
        .WIDTH (PERF_W)
    ) u_perf_cnt (
        .clk   (nvdla_core_clk),
        .rst   (nvdla_core_rst),
        .i_clr (bus.perf_clr),
        .i_inc (w_perf_inc),
        .o_cnt (bus.dp2reg_slcg_gated_cnt)
    );

    assign bus.slcg_en_src_0    = r_en0;
    assign bus.slcg_en_src_1    = r_en1;
    assign bus.dp2reg_slcg_viol = r_viol;

endmodule

`default_nettype wire

// File: tb/tb_cmac_slcg_en_ctrl.sv
// ============================================================================
// Module  : tb_cmac_slcg_en_ctrl
// Brief   : Self-checking bench for cmac_slcg_en_ctrl (vectors, sequences, random).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cmac_slcg_en_ctrl;

    localparam int HOLD = 16;
    localparam int PW   = 8;

    logic clk;
    logic rst;

    cmac_slcg_en_ctrl_if #(.PERF_W(PW)) bus();

    cmac_slcg_en_ctrl #(
        .HOLD_CYCLES (HOLD),
        .CNT_W       (5),
        .PERF_W      (PW)
    ) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .bus            (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: en0 is on while fewer than HOLD+1 edges have passed since the last activity.
    int          m_idle;
    logic        m_en0;
    logic        m_en1;
    logic        m_viol;
    logic [PW-1:0] m_cnt;

    typedef struct {
        logic rst, op, sop, dat, wt, mac, clr;
        int   reps;
        logic e_en0, e_en1, e_viol;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic op, input logic sop, input logic d,
                        input logic w, input logic m, input logic c);
        logic pv;
        rst                   = r;
        bus.reg2dp_op_en      = op;
        bus.reg2dp_slcg_op_en = sop;
        bus.sc2mac_dat_pvld   = d;
        bus.sc2mac_wt_pvld    = w;
        bus.mac2accu_pvld     = m;
        bus.perf_clr          = c;
        @(posedge clk);
        if (r) begin
            m_idle = 1; m_en0 = 1'b1; m_en1 = 1'b1; m_viol = 1'b0; m_cnt = '0;
        end else begin
            pv = d | w | m;
            if (c) m_cnt = '0;
            else if (!m_en0 && !m_en1 && m_cnt != '1) m_cnt = m_cnt + 1'b1;
            if (pv && !m_en0) m_viol = 1'b1;
            else if (c) m_viol = 1'b0;
            m_idle = (op | pv) ? 0 : ((m_idle > HOLD) ? m_idle : m_idle + 1);
            m_en0  = (m_idle <= HOLD);
            m_en1  = ~sop;
        end
        #1;
        check("model_en0",  32'(bus.slcg_en_src_0), 32'(m_en0));
        check("model_en1",  32'(bus.slcg_en_src_1), 32'(m_en1));
        check("model_viol", 32'(bus.dp2reg_slcg_viol), 32'(m_viol));
        check("model_cnt",  32'(bus.dp2reg_slcg_gated_cnt), 32'(m_cnt));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        m_idle = 1; m_en0 = 1'b1; m_en1 = 1'b1; m_viol = 1'b0; m_cnt = '0;

        //            rst op  sop dat wt  mac clr reps en0 en1 viol
        vecs[0]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2, 1'b1,1'b1,1'b0};
        vecs[1]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,16, 1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 1, 1'b1,1'b0,1'b1};
        vecs[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,16, 1'b1,1'b0,1'b1};
        vecs[4]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1, 1'b0,1'b0,1'b1};
        vecs[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 1, 1'b0,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1, 1'b0,1'b1,1'b0};
        vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 3, 1'b1,1'b1,1'b0};
        vecs[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1, 1'b1,1'b1,1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,15, 1'b1,1'b0,1'b0};
        vecs[10] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1, 1'b0,1'b0,1'b0};
        vecs[11] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1, 1, 1'b1,1'b0,1'b1};

        // Reset and power-up drain.
        step(1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        check("rst_en0",  32'(bus.slcg_en_src_0), 32'd1);
        check("rst_en1",  32'(bus.slcg_en_src_1), 32'd1);
        check("rst_viol", 32'(bus.dp2reg_slcg_viol), 32'd0);
        check("rst_cnt",  32'(bus.dp2reg_slcg_gated_cnt), 32'd0);
        for (int k = 1; k <= 15; k++) begin
            idle(1);
            check("pwrup_en0_on", 32'(bus.slcg_en_src_0), 32'd1);
        end
        idle(1);
        check("pwrup_en0_off", 32'(bus.slcg_en_src_0), 32'd0);
        check("pwrup_cnt0", 32'(bus.dp2reg_slcg_gated_cnt), 32'd0);
        idle(1);
        check("pwrup_cnt1", 32'(bus.dp2reg_slcg_gated_cnt), 32'd1);

        // Five-cycle op_en pulse out of GATED.
        step(0, 1, 1, 0, 0, 0, 0);
        check("op_rise_en0", 32'(bus.slcg_en_src_0), 32'd1);
        for (int k = 0; k < 4; k++) step(0, 1, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            idle(1);
            check("op_drain_en0", 32'(bus.slcg_en_src_0), 32'd1);
        end
        idle(1);
        check("op_fall_en0", 32'(bus.slcg_en_src_0), 32'd0);

        // Data valid at drain count 3 restarts a full drain.
        step(0, 1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 13; k++) begin
            idle(1);
            check("redrain_pre_en0", 32'(bus.slcg_en_src_0), 32'd1);
        end
        step(0, 0, 1, 1, 0, 0, 0);
        check("redrain_hit_en0", 32'(bus.slcg_en_src_0), 32'd1);
        check("redrain_no_viol", 32'(bus.dp2reg_slcg_viol), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            idle(1);
            check("redrain_en0", 32'(bus.slcg_en_src_0), 32'd1);
        end
        idle(1);
        check("redrain_off_en0", 32'(bus.slcg_en_src_0), 32'd0);

        // Weight valid while gated raises the sticky violation.
        step(0, 0, 1, 0, 1, 0, 0);
        check("viol_set", 32'(bus.dp2reg_slcg_viol), 32'd1);
        check("viol_en0", 32'(bus.slcg_en_src_0), 32'd1);
        step(0, 0, 1, 0, 0, 0, 1);
        check("viol_clr", 32'(bus.dp2reg_slcg_viol), 32'd0);

        // Software disable freezes the gated-cycle counter.
        idle(16);
        check("sw_gated_en0", 32'(bus.slcg_en_src_0), 32'd0);
        step(0, 0, 1, 0, 0, 0, 1);
        check("sw_clr_cnt", 32'(bus.dp2reg_slcg_gated_cnt), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("sw_en1", 32'(bus.slcg_en_src_1), 32'd1);
        check("sw_cnt_last", 32'(bus.dp2reg_slcg_gated_cnt), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            check("sw_cnt_frozen", 32'(bus.dp2reg_slcg_gated_cnt), 32'd1);
            check("sw_en0_low", 32'(bus.slcg_en_src_0), 32'd0);
        end
        idle(1);
        check("sw_en1_back", 32'(bus.slcg_en_src_1), 32'd0);
        check("sw_cnt_hold", 32'(bus.dp2reg_slcg_gated_cnt), 32'd1);
        idle(1);
        check("sw_cnt_resume", 32'(bus.dp2reg_slcg_gated_cnt), 32'd2);

        // Saturation and clear-on-increment.
        step(0, 0, 1, 0, 0, 0, 1);
        idle(254);
        check("sat_pre", 32'(bus.dp2reg_slcg_gated_cnt), 32'd254);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            check("sat_hold", 32'(bus.dp2reg_slcg_gated_cnt), 32'd255);
        end
        step(0, 0, 1, 0, 0, 0, 1);
        check("sat_clr", 32'(bus.dp2reg_slcg_gated_cnt), 32'd0);
        idle(1);
        step(0, 0, 1, 0, 0, 0, 1);
        check("clr_on_inc", 32'(bus.dp2reg_slcg_gated_cnt), 32'd0);

        // Vector table, starting from a fresh reset.
        for (int i = 0; i < 12; i++) begin
            for (int r = 0; r < vecs[i].reps; r++)
                step(vecs[i].rst, vecs[i].op, vecs[i].sop, vecs[i].dat,
                     vecs[i].wt, vecs[i].mac, vecs[i].clr);
            check($sformatf("vec%0d_en0", i),  32'(bus.slcg_en_src_0),    32'(vecs[i].e_en0));
            check($sformatf("vec%0d_en1", i),  32'(bus.slcg_en_src_1),    32'(vecs[i].e_en1));
            check($sformatf("vec%0d_viol", i), 32'(bus.dp2reg_slcg_viol), 32'(vecs[i].e_viol));
        end

        // Randomized traffic against the reference model.
        begin
            logic op, sop;
            op = 1'b0;
            sop = 1'b1;
            for (int k = 0; k < 4000; k++) begin
                if ($urandom_range(0, 39) == 0) op = ~op;
                if ($urandom_range(0, 99) == 0) sop = ~sop;
                step(($urandom_range(0, 499) == 0), op, sop,
                     ($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0),
                     ($urandom_range(0, 29) == 0), ($urandom_range(0, 49) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
